// File: rtl/ex_stage_if.sv
// Handshake and result bus between operand-select, execute and mem_req stages.
interface ex_stage_if;
  logic        in_valid;
  logic [3:0]  alu_op;
  logic [31:0] op_1;
  logic [31:0] op_2;
  logic [4:0]  rd;
  logic        reg_we;
  logic        stall_in;
  logic        flush;
  logic        busy;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;

  modport master (
    output in_valid, alu_op, op_1, op_2, rd, reg_we, stall_in, flush,
    input  busy, ex_valid, ex_alu_result, ex_rd, ex_reg_we
  );

  modport slave (
    input  in_valid, alu_op, op_1, op_2, rd, reg_we, stall_in, flush,
    output busy, ex_valid, ex_alu_result, ex_rd, ex_reg_we
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 32-iteration shift-add multiplier,
// feeding one registered output slot that doubles as the forwarding source.
module ex_stage (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB = 4'd1, OP_SLL = 4'd2,  OP_SLT    = 4'd3,
    OP_SLTU = 4'd4,  OP_XOR = 4'd5, OP_SRL = 4'd6,  OP_SRA    = 4'd7,
    OP_OR   = 4'd8,  OP_AND = 4'd9, OP_PASS_B = 4'd10,
    OP_MUL  = 4'd11, OP_MULHU = 4'd12
  } alu_op_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic        mul_hi;
  logic [4:0]  mul_rd;
  logic        mul_we;

  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;

  logic [31:0] alu_res;
  logic [4:0]  shamt;
  logic        is_mul;
  logic        accept;

  assign is_mul = (bus.alu_op == OP_MUL) || (bus.alu_op == OP_MULHU);
  assign accept = bus.in_valid && (state == IDLE) && !bus.stall_in && !bus.flush;

  always_comb begin
    shamt   = bus.op_2[4:0];
    alu_res = '0;
    case (bus.alu_op)
      OP_ADD:    alu_res = bus.op_1 + bus.op_2;
      OP_SUB:    alu_res = bus.op_1 - bus.op_2;
      OP_SLL:    alu_res = bus.op_1 << shamt;
      OP_SLT:    alu_res = {31'd0, $signed(bus.op_1) < $signed(bus.op_2)};
      OP_SLTU:   alu_res = {31'd0, bus.op_1 < bus.op_2};
      OP_XOR:    alu_res = bus.op_1 ^ bus.op_2;
      OP_SRL:    alu_res = bus.op_1 >> shamt;
      OP_SRA:    alu_res = $unsigned($signed(bus.op_1) >>> shamt);
      OP_OR:     alu_res = bus.op_1 | bus.op_2;
      OP_AND:    alu_res = bus.op_1 & bus.op_2;
      OP_PASS_B: alu_res = bus.op_2;
      default:   alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && is_mul) state_nxt = MUL;
        MUL:     if (count == 5'd31) state_nxt = DONE;
        DONE:    if (!bus.stall_in) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right, LSB-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mul_hi <= 1'b0;
      mul_rd <= '0;
      mul_we <= 1'b0;
    end else if (bus.flush) begin
      count <= '0;
    end else if (accept && is_mul) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= {32'd0, bus.op_1};
      mplier <= bus.op_2;
      mul_hi <= (bus.alu_op == OP_MULHU);
      mul_rd <= bus.rd;
      mul_we <= bus.reg_we;
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 5'd1;
    end
  end

  // Output slot: flush beats everything; an idle stall is the only case that holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_we     <= 1'b0;
    end else if (bus.flush || (state == MUL) || (state == DONE && bus.stall_in)) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_we     <= 1'b0;
    end else if (state == DONE) begin
      out_valid  <= 1'b1;
      out_result <= mul_hi ? acc[63:32] : acc[31:0];
      out_rd     <= mul_rd;
      out_we     <= mul_we && (mul_rd != '0);
    end else if (!bus.stall_in) begin
      if (bus.in_valid && !is_mul) begin
        out_valid  <= 1'b1;
        out_result <= alu_res;
        out_rd     <= bus.rd;
        out_we     <= bus.reg_we && (bus.rd != '0);
      end else begin
        out_valid  <= 1'b0;
        out_result <= '0;
        out_rd     <= '0;
        out_we     <= 1'b0;
      end
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.ex_valid      = out_valid;
  assign bus.ex_alu_result = out_result;
  assign bus.ex_rd         = out_rd;
  assign bus.ex_reg_we     = out_we;

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized checks of ex_stage against an arithmetic reference model.
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic        m_valid;
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  logic        m_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble_model();
    m_valid = 1'b0; m_res = '0; m_rd = '0; m_we = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic exp_busy);
    chk({tag, "_valid"}, bus.ex_valid, m_valid);
    chk({tag, "_result"}, bus.ex_alu_result, m_res);
    chk({tag, "_rd"}, bus.ex_rd, m_rd);
    chk({tag, "_we"}, bus.ex_reg_we, m_we);
    chk({tag, "_busy"}, bus.busy, exp_busy);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  begin ext = {{32{a[31]}}, a} >> sh; return ext[31:0]; end
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Applies one IDLE-stage cycle and updates the model the way the stage must behave.
  task automatic idle_cycle(input string tag, input logic iv, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                            input logic w, input logic st, input logic fl);
    bus.in_valid = iv; bus.alu_op = op; bus.op_1 = a; bus.op_2 = b;
    bus.rd = r; bus.reg_we = w; bus.stall_in = st; bus.flush = fl;
    step();
    if (fl) bubble_model();
    else if (!st) begin
      if (iv) begin
        m_valid = 1'b1; m_res = ref_alu(op, a, b); m_rd = r; m_we = w && (r != 5'd0);
      end else bubble_model();
    end
    check_out(tag, 1'b0);
    bus.in_valid = 1'b0; bus.stall_in = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic hi, input logic [4:0] r, input logic w,
                         input int sf, input int st);
    int done_k;
    logic [63:0] p;
    done_k = 33;
    while (done_k >= sf && done_k <= st) done_k++;
    p = {32'd0, a} * {32'd0, b};
    bus.in_valid = 1'b1; bus.alu_op = hi ? 4'd12 : 4'd11; bus.op_1 = a; bus.op_2 = b;
    bus.rd = r; bus.reg_we = w; bus.stall_in = 1'b0; bus.flush = 1'b0;
    step();
    bubble_model();
    check_out({tag, "_accept"}, 1'b1);
    bus.alu_op = 4'd0; bus.op_1 = $urandom; bus.op_2 = $urandom; bus.rd = 5'd3;
    for (int k = 1; k <= 80; k++) begin
      bus.stall_in = (k >= sf && k <= st);
      step();
      if (k == done_k) begin
        m_valid = 1'b1; m_res = hi ? p[63:32] : p[31:0]; m_rd = r; m_we = w && (r != 5'd0);
        check_out({tag, "_done"}, 1'b0);
        break;
      end
      chk({tag, "_busy"}, bus.busy, 1'b1);
      chk({tag, "_bubble_valid"}, bus.ex_valid, 1'b0);
      chk({tag, "_bubble_we"}, bus.ex_reg_we, 1'b0);
    end
    bus.in_valid = 1'b0; bus.stall_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;

    bus.in_valid = 1'b0; bus.alu_op = '0; bus.op_1 = '0; bus.op_2 = '0;
    bus.rd = '0; bus.reg_we = 1'b0; bus.stall_in = 1'b0; bus.flush = 1'b0;
    bubble_model();
    #1;
    check_out("reset", 1'b0);
    step();
    rst = 1'b0;

    idle_cycle("add_wrap", 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("add_wrap_const", bus.ex_alu_result, 32'h0);
    idle_cycle("sra", 1'b1, 4'd7, 32'h8000_0000, 32'h24, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("sra_const", bus.ex_alu_result, 32'hF800_0000);
    idle_cycle("slt", 1'b1, 4'd3, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("slt_const", bus.ex_alu_result, 32'd1);
    idle_cycle("sltu", 1'b1, 4'd4, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("sltu_const", bus.ex_alu_result, 32'd0);
    idle_cycle("add_rd0", 1'b1, 4'd0, 32'd4, 32'd9, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("add_rd0_we", bus.ex_reg_we, 1'b0);
    idle_cycle("reserved", 1'b1, 4'd14, 32'h1234, 32'h5678, 5'd9, 1'b1, 1'b0, 1'b0);
    idle_cycle("bubble", 1'b0, 4'd0, 32'd1, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0);

    run_mul("mul", 32'h0001_0000, 32'h0001_0000, 1'b0, 5'd10, 1'b1, 100, 0);
    run_mul("mulhu", 32'h0001_0000, 32'h0001_0000, 1'b1, 5'd11, 1'b1, 100, 0);
    chk("mulhu_const", bus.ex_alu_result, 32'd1);
    run_mul("mul_stall", 32'd7, 32'd6, 1'b0, 5'd12, 1'b1, 30, 40);
    chk("mul_stall_const", bus.ex_alu_result, 32'd42);

    for (int i = 0; i < 3; i++)
      idle_cycle("idle_stall_hold", 1'b1, 4'd0, 32'd1, 32'd2, 5'd4, 1'b1, 1'b1, 1'b0);
    chk("idle_stall_const", bus.ex_alu_result, 32'd42);
    idle_cycle("flush_over_stall", 1'b1, 4'd0, 32'd1, 32'd2, 5'd4, 1'b1, 1'b1, 1'b1);
    idle_cycle("flush_incoming", 1'b1, 4'd0, 32'd1, 32'd2, 5'd4, 1'b1, 1'b0, 1'b1);

    // flush on the tenth cycle of a multiply
    bus.in_valid = 1'b1; bus.alu_op = 4'd11; bus.op_1 = 32'd3; bus.op_2 = 32'd5;
    bus.rd = 5'd8; bus.reg_we = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 1; k < 10; k++) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bubble_model();
    check_out("mul_flush", 1'b0);
    for (int k = 0; k < 40; k++) begin
      step();
      chk("mul_flush_quiet", bus.ex_valid, 1'b0);
    end

    // asynchronous reset in the middle of a multiply
    bus.in_valid = 1'b1; bus.alu_op = 4'd12; bus.op_1 = 32'hFFFF_FFFF; bus.op_2 = 32'hFFFF_FFFF;
    bus.rd = 5'd9; bus.reg_we = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 1; k < 10; k++) step();
    #2 rst = 1'b1;
    #1;
    check_out("mul_rst", 1'b0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      chk("mul_rst_quiet_valid", bus.ex_valid, 1'b0);
      chk("mul_rst_quiet_busy", bus.busy, 1'b0);
    end

    // first edge after reset release accepts
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_cycle("post_rst_accept", 1'b1, 4'd1, 32'd10, 32'd3, 5'd2, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 13));
      if (op >= 4'd11) op = op + 4'd2;
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 7 == 0) a = 32'h8000_0000 | a;
      idle_cycle("rand", ($urandom_range(0, 5) != 0), op, a, b, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end

    run_mul("rand_mul", $urandom, $urandom, 1'b0, 5'd13, 1'b1, 100, 0);
    run_mul("rand_mulhu", $urandom, $urandom, 1'b1, 5'd0, 1'b1, 33, 35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
